// File: rtl/stopwatch_bcd_multi_if.sv
// Control and status bundle for the BCD stopwatch.
// The master side (host FSM or button logic) drives the controls and preset;
// the slave side (the stopwatch itself) returns the count, lap capture, tick and overflow.
interface stopwatch_bcd_multi_if #(
    parameter int NDIG = 3
);
    logic              go;
    logic              clr;
    logic              up;
    logic              load;
    logic [4*NDIG-1:0] load_val;
    logic              lap;
    logic [4*NDIG-1:0] digits;
    logic [4*NDIG-1:0] lap_digits;
    logic              tick;
    logic              ovf;

    modport master (
        output go, clr, up, load, load_val, lap,
        input  digits, lap_digits, tick, ovf
    );

    modport slave (
        input  go, clr, up, load, load_val, lap,
        output digits, lap_digits, tick, ovf
    );
endinterface

// File: rtl/stopwatch_bcd_multi.sv
// N-digit BCD stopwatch/timer.
// A prescaler divides clk down to a one-cycle count tick. On each tick the digit
// chain steps up or down by one with carry/borrow, either wrapping at the limit
// or saturating there. A sticky ovf flag records every wrap and every tick that
// was blocked at a saturated limit.
// Optional feature macro: STOPWATCH_LAP_EN adds a lap capture register; without
// it lap is ignored and lap_digits reads as zero.
module stopwatch_bcd_multi #(
    parameter int DVSR = 5000000,
    parameter int NDIG = 3,
    parameter int WRAP = 1
) (
    input logic                 clk,
    input logic                 reset,
    stopwatch_bcd_multi_if.slave bus
);

    localparam int            PW    = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(DVSR - 1);
    localparam int            W     = 4 * NDIG;

    logic [PW-1:0] p_q;
    logic [W-1:0]  digits_q;
    logic          ovf_q;

    logic          tick_int;
    logic [W-1:0]  step_digits;
    logic [W-1:0]  load_clamped;
    logic          at_limit;
    logic          all_nine;
    logic          all_zero;
    logic          carry;
    logic [3:0]    nib;

    // The tick is only a function of registered prescaler state, so a clr or
    // load in the same cycle can cleanly suppress it.
    assign tick_int = bus.go & (p_q == P_MAX) & ~bus.clr & ~bus.load & ~reset;

    assign bus.tick   = tick_int;
    assign bus.digits = digits_q;
    assign bus.ovf    = ovf_q;

    // One count step in the selected direction, rippling carry/borrow upward,
    // plus detection of whether the count already sits at the limit for that direction.
    always_comb begin
        step_digits = digits_q;
        carry       = 1'b1;
        all_nine    = 1'b1;
        all_zero    = 1'b1;
        nib         = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            nib = digits_q[4*i +: 4];
            if (nib != 4'd9) all_nine = 1'b0;
            if (nib != 4'd0) all_zero = 1'b0;
            if (carry) begin
                if (bus.up) begin
                    if (nib == 4'd9) begin
                        step_digits[4*i +: 4] = 4'd0;
                    end else begin
                        step_digits[4*i +: 4] = nib + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        step_digits[4*i +: 4] = 4'd9;
                    end else begin
                        step_digits[4*i +: 4] = nib - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        at_limit = bus.up ? all_nine : all_zero;
    end

    // Preset values that are not valid BCD are clamped to 9 so the count never holds a bad nibble.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < NDIG; i++) begin
            load_clamped[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
        end
    end

    // Prescaler, digit chain and overflow flag, in priority reset > clr > load > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q      <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else if (bus.clr) begin
            p_q      <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
        end else if (bus.load) begin
            p_q      <= '0;
            digits_q <= load_clamped;
        end else begin
            if (bus.go) begin
                p_q <= (p_q == P_MAX) ? '0 : p_q + PW'(1);
            end
            if (tick_int) begin
                if (at_limit) begin
                    ovf_q <= 1'b1;
                end
                if (!(at_limit && (WRAP == 0))) begin
                    digits_q <= step_digits;
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [W-1:0] lap_q;

    // Lap capture takes the count as it was before this cycle's tick or load lands.
    always_ff @(posedge clk) begin
        if (reset || bus.clr) begin
            lap_q <= '0;
        end else if (bus.lap) begin
            lap_q <= digits_q;
        end
    end

    assign bus.lap_digits = lap_q;
`else
    logic lap_unused;

    assign lap_unused     = bus.lap;
    assign bus.lap_digits = '0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_multi.sv
// Self-checking bench for stopwatch_bcd_multi (DVSR=4, NDIG=3, WRAP=1).
// The reference model holds the count as a plain integer and converts it to BCD
// only for comparison; directed scenarios are followed by randomized traffic.
module tb_stopwatch_bcd_multi;

    localparam int DVSR = 4;
    localparam int NDIG = 3;
    localparam int WRAP = 1;
    localparam int W    = 4 * NDIG;
    localparam int MAXV = 10 ** NDIG - 1;

    logic clk = 1'b0;
    logic reset;

    stopwatch_bcd_multi_if #(.NDIG(NDIG)) bus ();

    stopwatch_bcd_multi #(
        .DVSR(DVSR),
        .NDIG(NDIG),
        .WRAP(WRAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_val;
    int m_p;
    int m_lap;
    bit m_ovf;
    bit last_tick;
    int tick_count;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           div;
        r   = '0;
        div = 1;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'((v / div) % 10);
            div         = div * 10;
        end
        return r;
    endfunction

    function automatic int clamped_value(input logic [W-1:0] b);
        int v;
        int div;
        int n;
        v   = 0;
        div = 1;
        for (int i = 0; i < NDIG; i++) begin
            n   = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            v   = v + n * div;
            div = div * 10;
        end
        return v;
    endfunction

    // Drive one cycle of inputs, check the combinational tick, let the edge pass,
    // advance the reference model and check the registered outputs.
    task automatic applyStimulus(input bit rst, input bit go, input bit clr, input bit up,
                                 input bit load, input logic [W-1:0] lv, input bit lap);
        bit exp_tick;
        reset        = rst;
        bus.go       = go;
        bus.clr      = clr;
        bus.up       = up;
        bus.load     = load;
        bus.load_val = lv;
        bus.lap      = lap;
        #2;
        exp_tick = go && (m_p == DVSR - 1) && !clr && !load && !rst;
        checkOutput("tick", {31'd0, bus.tick}, {31'd0, exp_tick});
        last_tick = bus.tick;
        if (bus.tick) tick_count++;
        @(posedge clk);
        if (rst) begin
            m_val = 0;
            m_p   = 0;
            m_ovf = 1'b0;
            m_lap = 0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (clr) m_lap = 0;
            else if (lap) m_lap = m_val;
`endif
            if (clr) begin
                m_val = 0;
                m_p   = 0;
                m_ovf = 1'b0;
            end else if (load) begin
                m_val = clamped_value(lv);
                m_p   = 0;
            end else if (go) begin
                if (m_p == DVSR - 1) begin
                    m_p = 0;
                    if (up) begin
                        if (m_val == MAXV) begin
                            m_ovf = 1'b1;
                            if (WRAP != 0) m_val = 0;
                        end else begin
                            m_val = m_val + 1;
                        end
                    end else begin
                        if (m_val == 0) begin
                            m_ovf = 1'b1;
                            if (WRAP != 0) m_val = MAXV;
                        end else begin
                            m_val = m_val - 1;
                        end
                    end
                end else begin
                    m_p = m_p + 1;
                end
            end
        end
        #1;
        checkOutput("digits", 32'(bus.digits), 32'(to_bcd(m_val)));
        checkOutput("ovf", {31'd0, bus.ovf}, {31'd0, m_ovf});
        checkOutput("lap_digits", 32'(bus.lap_digits), 32'(to_bcd(m_lap)));
    endtask

    // Directed scenarios first, then randomized traffic against the model.
    initial begin
        bit          r_go;
        bit          r_up;
        bit          r_clr;
        bit          r_load;
        bit          r_lap;
        bit          r_rst;
        logic [W-1:0] r_lv;

        m_val      = 0;
        m_p        = 0;
        m_ovf      = 1'b0;
        m_lap      = 0;
        tick_count = 0;

        // Reset with go high: tick must stay low, everything clears.
        applyStimulus(1, 1, 0, 1, 0, '0, 0);
        applyStimulus(1, 1, 0, 1, 0, '0, 0);
        checkOutput("reset_digits", 32'(bus.digits), 32'h000);

        // Count up for 40 cycles: ten ticks, ending at 010.
        tick_count = 0;
        for (int i = 0; i < 40; i++) applyStimulus(0, 1, 0, 1, 0, '0, 0);
        checkOutput("t1_ticks", 32'(tick_count), 32'd10);
        checkOutput("t1_digits", 32'(bus.digits), 32'h010);
        checkOutput("t1_ovf", {31'd0, bus.ovf}, 32'd0);

        // Wrap upward from 999.
        applyStimulus(0, 1, 0, 1, 1, 12'h999, 0);
        for (int i = 0; i < DVSR; i++) applyStimulus(0, 1, 0, 1, 0, '0, 0);
        checkOutput("t2_digits", 32'(bus.digits), (WRAP != 0) ? 32'h000 : 32'h999);
        checkOutput("t2_ovf", {31'd0, bus.ovf}, 32'd1);

        // Borrow chain 100 -> 099, then wrap downward from 000.
        applyStimulus(0, 1, 1, 0, 0, '0, 0);
        applyStimulus(0, 1, 0, 0, 1, 12'h100, 0);
        for (int i = 0; i < DVSR; i++) applyStimulus(0, 1, 0, 0, 0, '0, 0);
        checkOutput("t3_borrow", 32'(bus.digits), 32'h099);
        applyStimulus(0, 1, 0, 0, 1, 12'h000, 0);
        for (int i = 0; i < DVSR; i++) applyStimulus(0, 1, 0, 0, 0, '0, 0);
        checkOutput("t3_wrapdown", 32'(bus.digits), 32'h999);
        checkOutput("t3_ovf", {31'd0, bus.ovf}, 32'd1);

        // Invalid BCD preset is clamped; clr beats a simultaneous load.
        applyStimulus(0, 0, 0, 1, 1, 12'hAF3, 0);
        checkOutput("t4_clamp", 32'(bus.digits), 32'h993);
        applyStimulus(0, 1, 1, 1, 1, 12'h555, 0);
        checkOutput("t4_clr_digits", 32'(bus.digits), 32'h000);
        checkOutput("t4_clr_ovf", {31'd0, bus.ovf}, 32'd0);

        // Pause mid-period: prescaler freezes and the period resumes where it left off.
        applyStimulus(0, 1, 0, 1, 0, '0, 0);
        applyStimulus(0, 1, 0, 1, 0, '0, 0);
        tick_count = 0;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, '0, 0);
        checkOutput("t5_no_tick_paused", 32'(tick_count), 32'd0);
        applyStimulus(0, 1, 0, 1, 0, '0, 0);
        checkOutput("t5_resume1", {31'd0, last_tick}, 32'd0);
        applyStimulus(0, 1, 0, 1, 0, '0, 0);
        checkOutput("t5_resume2", {31'd0, last_tick}, 32'd1);

        // Lap capture in the same cycle as a tick keeps the old count.
        applyStimulus(0, 0, 0, 1, 1, 12'h042, 0);
        for (int i = 0; i < DVSR - 1; i++) applyStimulus(0, 1, 0, 1, 0, '0, 0);
        applyStimulus(0, 1, 0, 1, 0, '0, 1);
        checkOutput("t6_tick", {31'd0, last_tick}, 32'd1);
        checkOutput("t6_digits", 32'(bus.digits), 32'h043);
`ifdef STOPWATCH_LAP_EN
        checkOutput("t6_lap", 32'(bus.lap_digits), 32'h042);
`else
        checkOutput("t6_lap", 32'(bus.lap_digits), 32'h000);
`endif

        // Randomized traffic, biased toward the wrap/saturate limits.
        r_up = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r_rst  = ($urandom_range(0, 299) == 0);
            r_clr  = ($urandom_range(0, 59) == 0);
            r_load = ($urandom_range(0, 19) == 0);
            r_lap  = ($urandom_range(0, 7) == 0);
            r_go   = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 7) == 0) r_up = ~r_up;
            case ($urandom_range(0, 7))
                0:       r_lv = 12'h999;
                1:       r_lv = 12'h000;
                2:       r_lv = 12'h998;
                3:       r_lv = 12'h001;
                default: r_lv = W'($urandom);
            endcase
            applyStimulus(r_rst, r_go, r_clr, r_up, r_load, r_lv, r_lap);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
